// File: rtl/serial_pkg.sv
// serial_pkg: state codes, default bit timing and frame sizes for the serial receiver.
package serial_pkg;
  localparam int TICKS_POR_BIT_PADRAO = 5208;
  localparam int BITS_DADOS = 8;
  localparam int BITS_QUADRO = 10;
  localparam int BITS_QUADRO_PARIDADE = 11;
  typedef enum logic [3:0] {
    ST_INICIAL        = 4'd0,
    ST_CONFIRMA_START = 4'd1,
    ST_RECEBE         = 4'd2,
    ST_PARIDADE       = 4'd3,
    ST_STOP           = 4'd4,
    ST_ARMAZENA       = 4'd5,
    ST_ESPERA_LINHA   = 4'd6
  } estado_t;
endpackage

// File: rtl/contador_ticks.sv
// contador_ticks: modulo-M tick counter with terminal (fim) and half-period (meio) flags.
module contador_ticks #(
  parameter int M = 16,
  parameter int W = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim,
  output logic meio
);
  logic [W-1:0] cnt_q;
  assign fim  = cnt_q == W'(M - 1);
  assign meio = cnt_q == W'(M / 2 - 1);
  always_ff @(posedge clock) begin
    if (reset || zera) cnt_q <= '0;
    else if (conta) cnt_q <= fim ? '0 : cnt_q + W'(1);
  end
endmodule

// File: rtl/receptor_serial.sv
// receptor_serial: 8N1 UART receiver with 2-flop synchronizer and one-cycle status pulses.
// Even parity (11-bit frames) is compiled in with RECEPTOR_PARIDADE_EN.
module receptor_serial
  import serial_pkg::*;
#(
  parameter int TICKS_POR_BIT = TICKS_POR_BIT_PADRAO,
  parameter int LARGURA_TICK  = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [7:0] dados,
  output logic       fim_recepcao,
  output logic       erro_frame,
  output logic       erro_paridade,
  output logic [3:0] db_estado
);
  estado_t    estado_q, estado_d;
  logic [1:0] sync_q;
  logic [7:0] shift_q, shift_d, dados_q, dados_d;
  logic [2:0] bit_q, bit_d;
  logic       fim_q, fim_d, erro_frame_q, erro_frame_d;
  logic       rx_s, tick_fim, tick_meio;
`ifdef RECEPTOR_PARIDADE_EN
  logic       par_q, par_d, erro_paridade_q, erro_paridade_d;
`endif

  assign rx_s = sync_q[1];

  // Counter restarts on every state change so each state measures from its own entry.
  contador_ticks #(.M(TICKS_POR_BIT), .W(LARGURA_TICK)) u_ticks (
    .clock(clock),
    .reset(reset),
    .zera (estado_d != estado_q),
    .conta(1'b1),
    .fim  (tick_fim),
    .meio (tick_meio)
  );

  always_comb begin
    estado_d     = estado_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    dados_d      = dados_q;
    fim_d        = 1'b0;
    erro_frame_d = 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
    par_d           = par_q;
    erro_paridade_d = 1'b0;
`endif
    case (estado_q)
      ST_INICIAL: estado_d = rx_s ? ST_INICIAL : ST_CONFIRMA_START;
      ST_CONFIRMA_START: if (tick_meio) begin
        estado_d = rx_s ? ST_INICIAL : ST_RECEBE;
        bit_d    = '0;
      end
      ST_RECEBE: if (tick_fim) begin
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
`ifdef RECEPTOR_PARIDADE_EN
        if (bit_q == 3'(BITS_DADOS - 1)) estado_d = ST_PARIDADE;
`else
        if (bit_q == 3'(BITS_DADOS - 1)) estado_d = ST_STOP;
`endif
      end
`ifdef RECEPTOR_PARIDADE_EN
      ST_PARIDADE: if (tick_fim) begin
        par_d    = ^shift_q ^ rx_s;
        estado_d = ST_STOP;
      end
`endif
      ST_STOP: if (tick_fim) begin
        if (!rx_s) begin
          erro_frame_d = 1'b1;
          estado_d     = ST_ESPERA_LINHA;
`ifdef RECEPTOR_PARIDADE_EN
        end else if (par_q) begin
          erro_paridade_d = 1'b1;
          estado_d        = ST_INICIAL;
`endif
        end else begin
          dados_d  = shift_q;
          fim_d    = 1'b1;
          estado_d = ST_ARMAZENA;
        end
      end
      ST_ARMAZENA: estado_d = ST_INICIAL;
      ST_ESPERA_LINHA: estado_d = rx_s ? ST_INICIAL : ST_ESPERA_LINHA;
      default: estado_d = ST_INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= ST_INICIAL;
      sync_q       <= 2'b11;
      shift_q      <= '0;
      bit_q        <= '0;
      dados_q      <= '0;
      fim_q        <= 1'b0;
      erro_frame_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      sync_q       <= {sync_q[0], entrada_serial};
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      dados_q      <= dados_d;
      fim_q        <= fim_d;
      erro_frame_q <= erro_frame_d;
    end
  end

`ifdef RECEPTOR_PARIDADE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      par_q           <= 1'b0;
      erro_paridade_q <= 1'b0;
    end else begin
      par_q           <= par_d;
      erro_paridade_q <= erro_paridade_d;
    end
  end
  assign erro_paridade = erro_paridade_q;
`else
  assign erro_paridade = 1'b0;
`endif

  assign dados        = dados_q;
  assign fim_recepcao = fim_q;
  assign erro_frame   = erro_frame_q;
  assign db_estado    = estado_q;
endmodule

// File: tb/tb_receptor_serial.sv
// tb_receptor_serial: directed frames against a timing model of the receiver's output events.
module tb_receptor_serial;
  localparam int T = 16;
`ifdef RECEPTOR_PARIDADE_EN
  localparam int NB  = 11;
  localparam int LAT = 171;
`else
  localparam int NB  = 10;
  localparam int LAT = 155;
`endif

  logic       clock = 1'b0, reset = 1'b1, entrada_serial = 1'b1;
  logic [7:0] dados;
  logic       fim_recepcao, erro_frame, erro_paridade;
  logic [3:0] db_estado;

  int         cyc = 0, checks = 0, errors = 0;
  logic       rst_prev = 1'b1;
  logic [7:0] model_dados = 8'h00;
  logic [7:0] exp_byte[int];
  bit         exp_ferr[int];
  bit         exp_perr[int];
  int         n_fim = 0, n_ferr = 0, n_perr = 0, k0 = 0;
  logic [7:0] got_q[$];
  int         fim_cyc[$];

  receptor_serial #(.TICKS_POR_BIT(T), .LARGURA_TICK(5)) dut (
    .clock         (clock),
    .reset         (reset),
    .entrada_serial(entrada_serial),
    .dados         (dados),
    .fim_recepcao  (fim_recepcao),
    .erro_frame    (erro_frame),
    .erro_paridade (erro_paridade),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_prev <= reset;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // Model: a frame started in cycle k produces its outcome in cycle
  // k + 2 (sync) + T/2 (start midpoint) + (NB-1)*T (remaining bits) + 1.
  always @(negedge clock) begin
    if (rst_prev) begin
      model_dados = 8'h00;
      exp_byte.delete();
      exp_ferr.delete();
      exp_perr.delete();
    end
    if (exp_byte.exists(cyc)) model_dados = exp_byte[cyc];
    check("fim_recepcao", int'(fim_recepcao), exp_byte.exists(cyc));
    check("erro_frame", int'(erro_frame), int'(exp_ferr.exists(cyc)));
    check("erro_paridade", int'(erro_paridade), int'(exp_perr.exists(cyc)));
    check("dados", int'(dados), int'(model_dados));
  end

  always @(negedge clock) begin
    if (fim_recepcao) begin
      n_fim++;
      got_q.push_back(dados);
      fim_cyc.push_back(cyc);
    end
    if (erro_frame) n_ferr++;
    if (erro_paridade) n_perr++;
  end

  task automatic drive(input logic v, input int n);
    entrada_serial = v;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    int ev;
    logic [NB-1:0] f;
    ev = cyc + 2 + T / 2 + (NB - 1) * T + 1;
`ifdef RECEPTOR_PARIDADE_EN
    f = {stop, par, b, 1'b0};
    if (!stop) exp_ferr[ev] = 1'b1;
    else if (par != ^b) exp_perr[ev] = 1'b1;
    else exp_byte[ev] = b;
`else
    f = {stop, b, 1'b0};
    if (!stop) exp_ferr[ev] = 1'b1;
    else exp_byte[ev] = b;
`endif
    for (int i = 0; i < NB; i++) drive(f[i], T);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, ^b);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    drive(1'b1, 5);
    check("estado_apos_reset", int'(db_estado), 0);

    k0 = cyc;
    send_good(8'h41);
    drive(1'b1, 10);
    check("n_fim_41", n_fim, 1);
    check("byte_41", int'(got_q[0]), 8'h41);
    check("latencia_41", fim_cyc[0] - k0, LAT);
    check("n_ferr_41", n_ferr, 0);

    send_frame(8'h55, 1'b0, ^8'h55);
    drive(1'b0, 40);
    check("estado_break", int'(db_estado), 6);
    check("n_ferr_55", n_ferr, 1);
    check("dados_apos_erro", int'(dados), 8'h41);
    drive(1'b1, 1);
    check("estado_espera", int'(db_estado), 6);
    drive(1'b1, 3);
    check("estado_volta", int'(db_estado), 0);
    drive(1'b1, 10);

    drive(1'b0, 4);
    check("estado_glitch", int'(db_estado), 1);
    drive(1'b0, 1);
    drive(1'b1, 30);
    check("estado_pos_glitch", int'(db_estado), 0);
    check("n_fim_glitch", n_fim, 1);
    check("n_ferr_glitch", n_ferr, 1);

    send_good(8'h31);
    send_good(8'h32);
    drive(1'b1, 10);
    check("n_fim_b2b", n_fim, 3);
    check("byte_31", int'(got_q[1]), 8'h31);
    check("byte_32", int'(got_q[2]), 8'h32);
    check("intervalo_b2b", fim_cyc[2] - fim_cyc[1], NB * T);

`ifdef RECEPTOR_PARIDADE_EN
    send_frame(8'h07, 1'b1, 1'b0);
    drive(1'b1, 10);
    check("n_perr_07", n_perr, 1);
    check("dados_apos_perr", int'(dados), 8'h32);
    send_frame(8'h07, 1'b1, 1'b1);
    drive(1'b1, 10);
    check("dados_07", int'(dados), 8'h07);
    check("n_fim_07", n_fim, 4);
`endif

    drive(1'b0, T);
    for (int i = 0; i < 4; i++) drive(1'b1, T);
    drive(1'b0, T / 2);
    entrada_serial = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("estado_reset_meio", int'(db_estado), 0);
    check("dados_reset_meio", int'(dados), 0);
    reset = 1'b0;
    drive(1'b1, 10);
    send_good(8'hA5);
    drive(1'b1, 10);
    check("dados_A5", int'(dados), 8'hA5);
    check("ultimo_byte_A5", int'(got_q[got_q.size() - 1]), 8'hA5);
    check("n_perr_total", n_perr, NB == 11 ? 1 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/receptor_serial.md
# receptor_serial

Asynchronous serial receiver that turns the `entrada_serial` line into bytes for the gate-control datapath. It sits directly upstream of the command comparison and register logic: the captured byte feeds the command register, and the one-cycle `fim_recepcao` pulse drives that stage's end-of-reception input. Frame format is 8 data bits, LSB first, one stop bit, with an optional even-parity bit.

## Interface
Parameters:
- `TICKS_POR_BIT`, default 5208 (50 MHz / 9600 baud): clock cycles per bit; ≥ 4, must be even.
- `LARGURA_TICK`, default 13: width of the tick counter; must hold `TICKS_POR_BIT-1`.

Ports:
- `clock`  in  1: single system clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high; clears every register and output.
- `entrada_serial`  in  1: asynchronous serial line; idle level is 1.
- `dados`  out  8: last correctly received byte; reset value 8'h00.
- `fim_recepcao`  out  1: one-cycle pulse when `dados` is updated; reset value 0.
- `erro_frame`  out  1: one-cycle pulse when the stop bit reads 0; reset value 0.
- `erro_paridade`  out  1: one-cycle pulse on a parity mismatch; reset value 0. Tied to 0 when parity is compiled out.
- `db_estado`  out  4: current FSM state code, for debug; reset value 0 (`inicial`).

## Operation
- `entrada_serial` passes through a 2-flop synchronizer. All decisions use the synchronized value `rx_s`. The synchronizer flops reset to 1.
- FSM states and codes:
  - `inicial` 0: if `rx_s`=0, go to `confirma_start`; otherwise stay.
  - `confirma_start` 1: count `TICKS_POR_BIT/2` cycles, then sample. If `rx_s`=0, go to `recebe` with bit index 0. If `rx_s`=1 (glitch), return to `inicial` with no output.
  - `recebe` 2: count `TICKS_POR_BIT` cycles, then shift `rx_s` into the shift register at the MSB and shift right. After bit index 7, go to `paridade` (if `PARITY_EN`) or `stop`.
  - `paridade` 3: after `TICKS_POR_BIT` cycles, sample the parity bit. The mismatch flag is `^shift ^ rx_s` (even parity, so the XOR of 9 bits must be 0).
  - `stop` 4: after `TICKS_POR_BIT` cycles, sample the stop bit.
    - Stop=1 and parity OK: go to `armazena`.
    - Stop=1 and parity mismatch: pulse `erro_paridade` and go to `inicial`.
    - Stop=0: pulse `erro_frame` and go to `espera_linha`.
  - `armazena` 5: load `dados` from the shift register, pulse `fim_recepcao`, go to `inicial`.
  - `espera_linha` 6: stay until `rx_s`=1, then go to `inicial`. A held-low line (break) does not retrigger reception.
- When both errors occur, only `erro_frame` pulses.
- `dados` changes only in `armazena` or on reset. An erroneous frame never modifies it.
- The tick counter clears on every state change. Each sample is taken on the cycle the counter reaches its terminal value.

## Timing
- Start detection: 2 cycles of synchronizer delay from the external falling edge.
- Samples land at the bit midpoints: start at +T/2, data bit k at +T/2+(k+1)·T, relative to the synchronized falling edge (T = `TICKS_POR_BIT`).
- `fim_recepcao` rises exactly 1 cycle after the stop-bit sample and lasts 1 cycle. `dados` is valid in that same cycle and holds until the next good frame.
- The error pulses coincide with the stop-bit sample cycle + 1.
- A new start bit may begin immediately after the stop-bit midpoint. `inicial` is re-entered in time for back-to-back frames.
- `reset` asserted in any state: next cycle the FSM is in `inicial`, all pulse outputs are 0, `dados`=0, and the partial frame is discarded.

## Configuration
- `RECEPTOR_PARIDADE_EN` defined: the `paridade` state exists and frames are 11 bits (start, 8 data, even parity, stop). `erro_paridade` is live.
- Undefined: `recebe` goes directly to `stop` and frames are 10 bits. `erro_paridade` is constant 0 and the parity XOR logic is not synthesized. Code 3 is never reached.

## Structure
- Shared package `serial_pkg`:
  - state encoding constants (`ST_INICIAL`..`ST_ESPERA_LINHA`, 4 bits);
  - default `TICKS_POR_BIT`;
  - frame bit-count constants.
- Sub-module `contador_ticks`: a modulo counter with `zera`, `conta`, a terminal-count output `fim`, and a half-count output `meio`. It is reused by the gate PWM timing.
- The FSM, shift register, synchronizer and output registers stay in `receptor_serial`.

## Test plan
The bench uses `TICKS_POR_BIT`=16.
- Good byte 8'h41 ("A"), parity disabled → `fim_recepcao` pulses once, `dados`=8'h41, and both error flags stay 0 throughout.
- Byte 8'h55 with stop bit forced to 0, then the line held low for 40 cycles → `erro_frame` pulses once, `dados` is unchanged, and the FSM sits in state 6 until the line returns high.
- Low glitch of 5 cycles on an idle line → no pulse on any output, and the FSM returns to state 0.
- Two back-to-back frames 8'h31 then 8'h32 with no idle gap → two `fim_recepcao` pulses, with `dados` equal to 8'h31 then 8'h32.
- With `RECEPTOR_PARIDADE_EN`: byte 8'h07 with parity bit 0 (wrong; correct is 1) → `erro_paridade` pulses, `dados` is unchanged. Same byte with parity 1 → `fim_recepcao`, `dados`=8'h07.
- `reset` pulsed during data bit 4 → the next cycle shows state 0 and `dados`=0. The following good frame 8'hA5 is received correctly.
